ex_mem_pipe_reg: RTL and testbench
==================================

EX_MEM_PIPE_REG -- requirements
Module: ex_mem_pipe_reg

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, width of ALU result and store data.
REQ-002 The block SHALL have parameter REG_ADDR_WIDTH, default 5, width of destination register index.
REQ-003 The block SHALL have parameter CTRL_WIDTH, default 3, width of control bundle (bit0 RegWrite, bit1 MemtoReg, bit2 MemWrite; extra bits user-defined).
REQ-004 The block SHALL have parameter STALL_CNT_WIDTH, default 16, width of stall counter.
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  EX stage presents a valid instruction.
REQ-008 in_ready  output  1  stage can accept an instruction this cycle.
REQ-009 ctrl_in  input  CTRL_WIDTH  EX control bundle.
REQ-010 alu_result_in  input  DATA_WIDTH  EX ALU result.
REQ-011 write_data_in  input  DATA_WIDTH  EX store data.
REQ-012 write_reg_in  input  REG_ADDR_WIDTH  EX destination register.
REQ-013 flush  input  1  discard all held and incoming instructions.
REQ-014 out_valid  output  1  MEM-side instruction valid.
REQ-015 out_ready  input  1  MEM stage accepts this cycle.
REQ-016 ctrl_out, alu_result_out, write_data_out, write_reg_out  output  widths as inputs  MEM-side copies.
REQ-017 stall_cnt  output  STALL_CNT_WIDTH  count of back-pressure cycles.

Function
REQ-018 Input transfer SHALL occur on an edge where in_valid and in_ready are both 1; output transfer where out_valid and out_ready are both 1.
REQ-019 Latency SHALL be exactly one cycle: an instruction accepted at edge N is presented on outputs after edge N when the stage was empty or draining.
REQ-020 Sustained throughput SHALL be one instruction per cycle when out_ready is held 1.
REQ-021 Data outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 ctrl_out SHALL be all zeros whenever out_valid=0, so RegWrite/MemWrite never reach MEM from a bubble.
REQ-023 Instructions SHALL leave in acceptance order; none duplicated or dropped except by flush.
REQ-024 flush=1 at an edge SHALL clear every held entry and discard any same-edge input transfer; out_valid=0 and ctrl_out=0 after that edge.
REQ-025 flush SHALL have priority over all simultaneous transfers; in_ready is not gated by flush.
REQ-026 stall_cnt SHALL increment by 1 on every edge with out_valid=1 and out_ready=0, saturating at all ones (no wrap).
REQ-027 flush SHALL NOT clear stall_cnt.

Reset
REQ-028 rst_n=0 SHALL immediately, independent of clk, force out_valid=0, ctrl_out=0, alu_result_out=0, write_data_out=0, write_reg_out=0, stall_cnt=0, and clear all internal entries.
REQ-029 in_ready SHALL be 1 while rst_n=0 and after deassertion; reset asserted mid-transfer SHALL discard that instruction.

Configuration
REQ-030 Macro EX_MEM_SKID_EN defined: two-entry storage (main + skid); in_ready SHALL be a register output equal to skid-entry-empty, with no combinational path from out_ready; accepted input while main full and not draining goes to skid; on output transfer skid moves to main in the same edge.
REQ-031 Macro EX_MEM_SKID_EN undefined: one-entry storage; in_ready SHALL equal (not out_valid) or out_ready, combinationally.
REQ-032 Both modes SHALL satisfy REQ-018 to REQ-029 identically at the ports, except in_ready timing.

Verification
REQ-033 Single push: after reset, in_valid=1, ctrl_in=3'b101, alu_result_in=32'h0000_1234, write_reg_in=5'd9, out_ready=1 for one cycle -> next cycle out_valid=1, ctrl_out=3'b101, alu_result_out=32'h0000_1234, write_reg_out=9; following cycle out_valid=0, ctrl_out=0.
REQ-034 Stream: 8 back-to-back pushes alu_result_in=1..8, out_ready=1 -> outputs 1..8 on 8 consecutive cycles, in_ready never 0.
REQ-035 Back-pressure: out_ready=0 for 5 cycles with instruction held -> outputs stable, stall_cnt=5; with EX_MEM_SKID_EN one more input accepted then in_ready=0; without macro in_ready=0 immediately; release -> both delivered in order.
REQ-036 Flush: two entries held (skid mode), flush=1 with in_valid=1 same edge -> next cycle out_valid=0, ctrl_out=0, no instruction ever emitted; stall_cnt unchanged.
REQ-037 Saturation and reset: STALL_CNT_WIDTH=4, out_ready=0 for 20 cycles -> stall_cnt=15; rst_n=0 asynchronously mid-cycle -> all outputs 0 and in_ready=1 before next edge.

Source files
------------

// File: rtl/ex_mem_pipe_reg.sv
// ex_mem_pipe_reg: EX->MEM pipeline register using a valid/ready handshake.
//
// Default build: a single entry. in_ready = !out_valid || out_ready, which is
// combinational on out_ready.
// Build with EX_MEM_SKID_EN defined: a main entry plus a skid entry. in_ready
// is a registered flag meaning "skid entry empty", so it has no combinational
// path from out_ready.
//
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   in_valid/in_ready EX-side handshake
//   ctrl_in           control bundle: bit0 RegWrite, bit1 MemtoReg, bit2 MemWrite
//   alu_result_in, write_data_in, write_reg_in   EX payload
//   flush             drop every held entry and any same-edge input
//   out_valid/out_ready MEM-side handshake
//   ctrl_out, alu_result_out, write_data_out, write_reg_out  MEM payload
//                     (ctrl_out is forced to zero while out_valid is low)
//   stall_cnt         saturating count of edges with out_valid && !out_ready
module ex_mem_pipe_reg #(
  parameter int DATA_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int CTRL_WIDTH      = 3,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_WIDTH-1:0]      ctrl_in,
  input  logic [DATA_WIDTH-1:0]      alu_result_in,
  input  logic [DATA_WIDTH-1:0]      write_data_in,
  input  logic [REG_ADDR_WIDTH-1:0]  write_reg_in,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_WIDTH-1:0]      ctrl_out,
  output logic [DATA_WIDTH-1:0]      alu_result_out,
  output logic [DATA_WIDTH-1:0]      write_data_out,
  output logic [REG_ADDR_WIDTH-1:0]  write_reg_out,
  output logic [STALL_CNT_WIDTH-1:0] stall_cnt
);

  typedef struct packed {
    logic [CTRL_WIDTH-1:0]     ctrl;
    logic [DATA_WIDTH-1:0]     alu;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [REG_ADDR_WIDTH-1:0] wreg;
  } entry_t;

  entry_t in_ent, main_q;
  logic   main_vld;
  logic   in_fire, out_fire;

  assign in_ent   = '{ctrl: ctrl_in, alu: alu_result_in, wdata: write_data_in, wreg: write_reg_in};
  assign in_fire  = in_valid && in_ready;
  assign out_fire = main_vld && out_ready;

`ifdef EX_MEM_SKID_EN
  entry_t skid_q;
  logic   skid_empty;

  // The skid entry can only fill when main is full and not draining, so
  // in_ready drops one cycle after MEM stalls, never combinationally.
  assign in_ready = skid_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld   <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
      skid_empty <= 1'b1;
    end else if (flush) begin
      main_vld   <= 1'b0;
      skid_empty <= 1'b1;
    end else if (out_fire) begin
      if (!skid_empty) begin
        main_q     <= skid_q;   // the older skid entry moves up; main stays valid
        skid_empty <= 1'b1;
      end else if (in_fire) begin
        main_q     <= in_ent;
      end else begin
        main_vld   <= 1'b0;
      end
    end else if (in_fire) begin
      if (main_vld) begin
        skid_q     <= in_ent;
        skid_empty <= 1'b0;
      end else begin
        main_q     <= in_ent;
        main_vld   <= 1'b1;
      end
    end
  end
`else
  assign in_ready = !main_vld || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld <= 1'b0;
      main_q   <= '0;
    end else if (flush) begin
      main_vld <= 1'b0;
    end else if (in_fire) begin
      main_q   <= in_ent;
      main_vld <= 1'b1;
    end else if (out_fire) begin
      main_vld <= 1'b0;
    end
  end
`endif

  // Back-pressure counter: flush does not clear it, and it saturates at all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (main_vld && !out_ready && !(&stall_cnt))
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign out_valid      = main_vld;
  assign ctrl_out       = main_vld ? main_q.ctrl : '0;  // a bubble never carries RegWrite/MemWrite
  assign alu_result_out = main_q.alu;
  assign write_data_out = main_q.wdata;
  assign write_reg_out  = main_q.wreg;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
module tb_ex_mem_pipe_reg;
  localparam int DW = 32, AW = 5, CW = 3, SW = 4;

  logic          clk, rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [CW-1:0] ctrl_in, ctrl_out;
  logic [DW-1:0] alu_result_in, write_data_in, alu_result_out, write_data_out;
  logic [AW-1:0] write_reg_in, write_reg_out;
  logic [SW-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  ex_mem_pipe_reg #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CTRL_WIDTH(CW), .STALL_CNT_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_in(ctrl_in), .alu_result_in(alu_result_in), .write_data_in(write_data_in),
    .write_reg_in(write_reg_in), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .ctrl_out(ctrl_out), .alu_result_out(alu_result_out), .write_data_out(write_data_out),
    .write_reg_out(write_reg_out), .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog");
  end

`ifdef EX_MEM_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge; outputs are sampled there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] a,
                       input logic [DW-1:0] w, input logic [AW-1:0] r);
    in_valid = v; ctrl_in = c; alu_result_in = a; write_data_in = w; write_reg_in = r;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    flush = 1'b0; out_ready = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ctrl_out", ctrl_out, 0);
    chk("rst_alu_out", alu_result_out, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    do_reset();

    // Single push
    drive(1'b1, 3'b101, 32'h0000_1234, 32'h0000_abcd, 5'd9);
    out_ready = 1'b1;
    step();
    drive(1'b0, '0, '0, '0, '0);
    chk("single_valid", out_valid, 1);
    chk("single_ctrl", ctrl_out, 3'b101);
    chk("single_alu", alu_result_out, 32'h0000_1234);
    chk("single_wdata", write_data_out, 32'h0000_abcd);
    chk("single_wreg", write_reg_out, 9);
    step();
    chk("single_drain_valid", out_valid, 0);
    chk("single_drain_ctrl", ctrl_out, 0);

    // Stream of 8 back-to-back pushes
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 3'b001, DW'(i), DW'(i * 16), AW'(i));
      #1;
      chk("stream_in_ready", in_ready, 1);
      step();
      chk("stream_valid", out_valid, 1);
      chk("stream_alu", alu_result_out, i);
    end
    drive(1'b0, '0, '0, '0, '0);
    step();
    chk("stream_end_valid", out_valid, 0);

    // Back-pressure: A held for 5 stall edges while B is offered
    do_reset();
    drive(1'b1, 3'b011, 32'hA, 32'hA0, 5'd1);
    step();
    chk("bp_a_valid", out_valid, 1);
    drive(1'b1, 3'b010, 32'hB, 32'hB0, 5'd2);
    #1;
    chk("bp_in_ready_first", in_ready, SKID);
    step();
    if (SKID) in_valid = 1'b0;
    #1;
    chk("bp_in_ready_after", in_ready, 0);
    for (int i = 2; i <= 5; i++) begin
      step();
      chk("bp_alu_stable", alu_result_out, 32'hA);
      chk("bp_ctrl_stable", ctrl_out, 3'b011);
    end
    chk("bp_stall5", stall_cnt, 5);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("bp_b_valid", out_valid, 1);
    chk("bp_b_alu", alu_result_out, 32'hB);
    chk("bp_b_ctrl", ctrl_out, 3'b010);
    step();
    chk("bp_empty", out_valid, 0);
    chk("bp_stall_kept", stall_cnt, 5);

    // Flush with held entries and a same-edge input
    do_reset();
    drive(1'b1, 3'b111, 32'h11, 32'h1, 5'd3);
    step();
    drive(1'b1, 3'b111, 32'h22, 32'h2, 5'd4);
    step();
    drive(1'b1, 3'b111, 32'h33, 32'h3, 5'd5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    chk("flush_valid", out_valid, 0);
    chk("flush_ctrl", ctrl_out, 0);
    chk("flush_stall", stall_cnt, 2);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush_no_emit", out_valid, 0);
    end
    chk("flush_stall_kept", stall_cnt, 2);

    // Saturation, then an asynchronous reset mid-cycle
    do_reset();
    drive(1'b1, 3'b001, 32'h55, 32'h5, 5'd7);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("sat_stall", stall_cnt, 15);
    chk("sat_held", alu_result_out, 32'h55);
    #2;
    drive(1'b1, 3'b111, 32'h66, 32'h6, 5'd8);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_ctrl", ctrl_out, 0);
    chk("arst_alu", alu_result_out, 0);
    chk("arst_wdata", write_data_out, 0);
    chk("arst_wreg", write_reg_out, 0);
    chk("arst_stall", stall_cnt, 0);
    chk("arst_in_ready", in_ready, 1);
    step();
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    step();
    chk("post_rst_no_emit", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
